regena_rr_arbiter: RTL
======================

// Module: regena_rr_arbiter
// PURPOSE
//  Round-robin write arbiter for one shared enabled 8-bit register.
//  - NREQ requesters each present a req and a data word; one write per cycle.
//  - The winner's word is loaded into the register, and the winner gets a one-cycle ack.
//  - Sits between requesting control blocks and the shared register; Q is readable by all.
// PARAMETERS
//  NREQ   4  number of requesters (2..8)
//  WIDTH  8  register/data width
// PORTS
//  clock     in   1           single clock; all state on rising edge
//  reset     in   1           asynchronous, active-low reset
//  req       in   NREQ        req[i]=1: requester i wants to write; held until ack[i] seen
//  wdata     in   NREQ*WIDTH  word i at wdata[i*WIDTH +: WIDTH]; stable while req[i]=1
//  ack       out  NREQ        one-hot, registered, 1-cycle pulse: write of requester i done
//  Q         out  WIDTH       current shared register contents
//  owner     out  clog2(NREQ) index of last requester written (registered)
//  wr_count  out  8           number of writes since reset, saturating at 8'hFF
// BEHAVIOUR
//  - Reset (reset=0, async): Q=0, ack=0, owner=0, wr_count=0, rr pointer ptr=0.
//    Any in-flight grant is discarded; requesters keep req high and are re-arbitrated after release.
//  - Eligible vector: elig = req & ~ack.
//    Masking a requester whose ack is high prevents a duplicate write while it drops req.
//  - Grant (combinational): the first i with elig[i]=1, searching ptr, ptr+1, ... mod NREQ.
//    No eligible requester: no grant, ena=0, Q holds.
//  - On the edge where a grant g exists:
//    - Q <= wdata[g]; ack <= onehot(g); owner <= g; ptr <= (g+1) mod NREQ.
//    - wr_count <= wr_count+1, unless it is already 8'hFF.
//  - Latency: req sampled high at edge k -> Q updated at edge k -> ack high from k to k+1.
//  - No grant at an edge: ack <= 0; ptr, owner, Q, wr_count unchanged.
//  - Fairness: a requester holding req is written within NREQ consecutive writes.
//  - Requester protocol: drop req (or present a new word) after sampling ack=1.
//    A req still high one cycle after its ack is treated as a new request.
//  - ack is never asserted for more than one requester, nor for two consecutive cycles to the same one.
//  - ptr wraps from NREQ-1 to 0; NREQ that is not a power of two uses explicit mod (no overflow into unused codes).
// STRUCTURE
//  - Shared package regena_pkg: REGENA_WIDTH=8, default NREQ, an index-width function, and the
//    WR_COUNT_MAX=8'hFF constant.
//  - Sub-module regena_rr_pick (combinational): inputs elig and ptr; outputs grant_valid and grant_idx.
//  - Storage uses the existing enabled register regena:
//    - clock, reset tied through;
//    - ena = grant_valid;
//    - R = wdata[grant_idx];
//    - Q wired to the output.
//  - Top level holds ptr, ack, owner and wr_count registers only.
// TESTING
//  1. Reset: hold reset=0 with req=4'hF -> Q=00, ack=0, owner=0, wr_count=0 throughout.
//  2. Single write: req=0001, wdata0=AA; drop req after ack.
//     -> Q=AA after 1 edge, ack=0001 for exactly 1 cycle, owner=0, wr_count=1, ptr=1.
//  3. All request: req=1111, words 11/22/33/44, each dropped after its ack.
//     -> Q sequence 11,22,33,44 on 4 consecutive edges; ack 0001,0010,0100,1000; no repeats.
//  4. Fairness: req0 and req2 re-request immediately after each ack.
//     -> grants alternate 0,2,0,2; neither gets two writes in a row.
//  5. Reset mid-operation: pull reset low while ack=0010.
//     -> ack, Q, wr_count clear immediately (asynchronously); after release, arbitration restarts at ptr=0.
//  6. Saturation: 300 back-to-back single-requester writes.
//     -> wr_count stops at FF; Q still tracks wdata.

Source files
------------

// File: rtl/regena_pkg.sv
// Shared definitions for the round-robin register write arbiter.
// Latency: none (constants and helper functions only).
// Backpressure: none.
package regena_pkg;

    // Width of the shared register and of each requester's data word
    localparam int REGENA_WIDTH = 8;

    // Default number of requesters
    localparam int REGENA_NREQ = 4;

    // Saturation value of the write counter
    localparam logic [7:0] WR_COUNT_MAX = 8'hFF;

    // Bits needed to hold a requester index; never less than one bit
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/regena.sv
// Enabled storage register: loads R when ena is high, otherwise holds.
// Latency: one clock from R/ena to Q.
// Backpressure: none; a load is accepted on every enabled edge.
module regena #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ena,
    input  logic [WIDTH-1:0] R,
    output logic [WIDTH-1:0] Q
);

    // Register with asynchronous clear and load enable
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            Q <= '0;
        end else if (ena) begin
            Q <= R;
        end
    end

endmodule

// File: rtl/regena_rr_pick.sv
// Round-robin picker: first eligible requester at or after ptr, wrapping modulo NREQ.
// Latency: purely combinational.
// Backpressure: none; grant_valid is low when nothing is eligible.
module regena_rr_pick
    import regena_pkg::*;
#(
    parameter  int NREQ = REGENA_NREQ,
    localparam int IW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] elig,
    input  logic [IW-1:0]   ptr,
    output logic            grant_valid,
    output logic [IW-1:0]   grant_idx
);

    // Scan ptr, ptr+1, ... with explicit wrap so non-power-of-two NREQ never
    // visits unused index codes; the first hit wins.
    always_comb begin
        int idx;
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!grant_valid && elig[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/regena_rr_arbiter.sv
// Round-robin write arbiter for one shared enabled register; one write per cycle.
// Latency: req sampled at edge k loads Q at edge k; ack pulses for one cycle after that edge.
// Backpressure: a requester holds req until it sees ack; the acked one is masked for a cycle.
module regena_rr_arbiter
    import regena_pkg::*;
#(
    parameter  int NREQ  = REGENA_NREQ,
    parameter  int WIDTH = REGENA_WIDTH,
    localparam int IW    = idx_w(NREQ)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] wdata,
    output logic [NREQ-1:0]       ack,
    output logic [WIDTH-1:0]      Q,
    output logic [IW-1:0]         owner,
    output logic [7:0]            wr_count
);

    logic [IW-1:0]    ptr;
    logic [NREQ-1:0]  elig;
    logic             grant_valid;
    logic [IW-1:0]    grant_idx;
    logic [NREQ-1:0]  grant_oh;
    logic [WIDTH-1:0] wr_word;
    logic [IW-1:0]    ptr_next;

    // A requester whose ack is high is still dropping req; do not write it twice
    assign elig = req & ~ack;

    regena_rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .elig        (elig),
        .ptr         (ptr),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    // Select the winner's word from the flattened data bus
    always_comb begin
        wr_word = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == IW'(i)) begin
                wr_word = wdata[i*WIDTH +: WIDTH];
            end
        end
    end

    // One-hot form of the grant, zero when nobody wins
    always_comb begin
        grant_oh = '0;
        if (grant_valid) begin
            grant_oh[grant_idx] = 1'b1;
        end
    end

    // Pointer moves just past the winner, wrapping explicitly at NREQ-1
    always_comb begin
        ptr_next = grant_idx + IW'(1);
        if (grant_idx == IW'(NREQ - 1)) begin
            ptr_next = '0;
        end
    end

    regena #(
        .WIDTH (WIDTH)
    ) u_reg (
        .clock (clock),
        .reset (reset),
        .ena   (grant_valid),
        .R     (wr_word),
        .Q     (Q)
    );

    // Arbitration state: ack pulse, last owner, rotation pointer, write count
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr      <= '0;
            ack      <= '0;
            owner    <= '0;
            wr_count <= '0;
        end else begin
            ack <= grant_oh;
            if (grant_valid) begin
                owner <= grant_idx;
                ptr   <= ptr_next;
                if (wr_count != WR_COUNT_MAX) begin
                    wr_count <= wr_count + 8'd1;
                end
            end
        end
    end

endmodule
